// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - parametrised oversampling UART receiver with parity, framing and break reporting
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-clk oversample strobe, OVERSAMPLE strobes per bit period
//   rx_in      serial line, idle high, asynchronous to clk
//   rx_out     last received data word, held until the next frame completes
//   rx_dv      one-clk pulse when a frame completes
//   parity_err parity mismatch on the last frame
//   frame_err  a stop bit sampled low on the last frame
//   break_det  one-clk pulse alongside rx_dv for a break frame
//   busy       high whenever the receiver is not idle
module uart_rx_ext #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_out,
    output logic                  rx_dv,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] S_LO  = CW'(M - 1);
    localparam logic [CW-1:0] S_MID = CW'(M);
    localparam logic [CW-1:0] S_DEC = CW'(M + 1);
    localparam logic [CW-1:0] S_END = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t                  state_q;
    logic                    rx_meta_q, rx_s_q;
    logic [CW-1:0]           s_cnt_q;
    logic [1:0]              samp_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BW-1:0]           bit_idx_q;
    logic                    stop_idx_q;
    logic                    perr_q, ferr_q, pbit_q;
    logic [DATA_WIDTH-1:0]   rx_out_q;
    logic                    rx_dv_q, parity_err_q, frame_err_q, break_det_q;

    logic maj, at_dec, at_end, parity_exp, last_stop, is_break;

    // The third sample is the live synchronized line at the decision tick.
    assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign at_dec     = tick && (s_cnt_q == S_DEC);
    assign at_end     = tick && (s_cnt_q == S_END);
    assign parity_exp = (PARITY_MODE == 1) ? ^data_q : ~^data_q;
    assign last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));
    // Break: everything low, including any earlier stop bit (latched in ferr_q).
    assign is_break   = (data_q == '0) && ((PARITY_MODE == 0) || !pbit_q) && !maj
                        && ((STOP_BITS == 1) || ferr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            s_cnt_q      <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            pbit_q       <= 1'b0;
            rx_out_q     <= '0;
            rx_dv_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            rx_dv_q     <= 1'b0;
            break_det_q <= 1'b0;

            // s_cnt is 0 in IDLE/BRK, so these never match outside a bit.
            if (tick && s_cnt_q == S_LO)  samp_q[0] <= rx_s_q;
            if (tick && s_cnt_q == S_MID) samp_q[1] <= rx_s_q;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q    <= START;
                        s_cnt_q    <= '0;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                        pbit_q     <= 1'b0;
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state_q <= IDLE;
                        s_cnt_q <= '0;
                    end else if (at_end) begin
                        state_q <= DATA;
                        s_cnt_q <= '0;
                    end else if (tick) begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (at_dec) data_q <= {maj, data_q[DATA_WIDTH-1:1]};
                    if (at_end) begin
                        s_cnt_q <= '0;
                        if (bit_idx_q == B_LAST) state_q <= (PARITY_MODE != 0) ? PARITY : STOP;
                        else                     bit_idx_q <= bit_idx_q + 1'b1;
                    end else if (tick) begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_dec) begin
                        pbit_q <= maj;
                        perr_q <= (maj != parity_exp);
                    end
                    if (at_end) begin
                        state_q <= STOP;
                        s_cnt_q <= '0;
                    end else if (tick) begin
                        s_cnt_q <= s_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (at_dec && last_stop) begin
                        // Finish early so a back-to-back start edge is not missed.
                        rx_out_q     <= data_q;
                        rx_dv_q      <= 1'b1;
                        parity_err_q <= perr_q;
                        frame_err_q  <= ferr_q | ~maj;
                        break_det_q  <= is_break;
                        state_q      <= is_break ? BRK : IDLE;
                        s_cnt_q      <= '0;
                    end else begin
                        if (at_dec) ferr_q <= ferr_q | ~maj;
                        if (at_end) begin
                            stop_idx_q <= 1'b1;
                            s_cnt_q    <= '0;
                        end else if (tick) begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                BRK: begin
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_out     = rx_out_q;
    assign rx_dv      = rx_dv_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb/tb_uart_rx_ext.sv - self-checking bench for uart_rx_ext (8N1, 8E1 and 7N2 instances)
module tb_uart_rx_ext;

    localparam int BITCLK = 128;   // 16 ticks per bit, one tick every 8 clks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] tcnt = '0;
    logic [2:0] rxl = 3'b111;
    logic [7:0] out0, out1;
    logic [6:0] out2;
    logic [2:0] dv, pe, fe, bk, bz;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt <= tcnt + 3'd1;
        tick <= (tcnt == 3'd7);
    end

    uart_rx_ext #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rxl[0]), .rx_out(out0), .rx_dv(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bk[0]), .busy(bz[0]));
    uart_rx_ext #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rxl[1]), .rx_out(out1), .rx_dv(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bk[1]), .busy(bz[1]));
    uart_rx_ext #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx_in(rxl[2]), .rx_out(out2), .rx_dv(dv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bk[2]), .busy(bz[2]));

    typedef struct {
        logic [8:0] data;
        bit         perr, ferr, brk;
    } exp_t;

    typedef struct {
        int         unit;
        bit         align;
        logic [8:0] data;
        bit         par_inv;
        bit         stop0;
        int         glitch;     // 0 none, 1 middle sample only, 2 all three samples of data bit 2
        int         idle_bits;
        logic [8:0] e_data;
        bit         e_perr, e_ferr, e_brk;
    } vec_t;

    exp_t q0[$], q1[$], q2[$];
    vec_t vecs[$];

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input int unit, input bit align, input logic [8:0] data,
                                input bit par_inv, input bit stop0, input int glitch,
                                input int idle_bits, input logic [8:0] e_data,
                                input bit e_perr, input bit e_ferr, input bit e_brk);
        vec_t v;
        v.unit = unit; v.align = align; v.data = data; v.par_inv = par_inv; v.stop0 = stop0;
        v.glitch = glitch; v.idle_bits = idle_bits; v.e_data = e_data;
        v.e_perr = e_perr; v.e_ferr = e_ferr; v.e_brk = e_brk;
        return v;
    endfunction

    task automatic push_exp(input int unit, input logic [8:0] d, input bit p, input bit f, input bit b);
        exp_t e;
        e.data = d; e.perr = p; e.ferr = f; e.brk = b;
        case (unit)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Leaves the caller on the negedge right after a tick, so samples land mid-bit.
    task automatic align_tick();
        do @(posedge clk); while (!tick);
        @(negedge clk);
    endtask

    task automatic send_frame(input int unit, input logic [8:0] data, input bit par_inv,
                              input bit stop0, input int glitch, input int idle_bits,
                              input int max_clks);
        bit bits[$];
        int w, pm, ns, n;
        bit p, v;
        w  = (unit == 2) ? 7 : 8;
        pm = (unit == 1) ? 1 : 0;
        ns = (unit == 2) ? 2 : 1;
        p  = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (pm != 0) bits.push_back(p ^ par_inv);
        for (int s = 0; s < ns; s++) bits.push_back(!stop0);
        for (int s = 0; s < idle_bits; s++) bits.push_back(1'b1);
        n = 0;
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < BITCLK; c++) begin
                v = bits[k];
                if (k == 3 && glitch == 1 && c >= 66 && c <= 73) v = !v;
                if (k == 3 && glitch == 2 && c >= 56 && c <= 84) v = !v;
                rxl[unit] = v;
                if (max_clks > 0 && n >= max_clks) return;
                n++;
                @(negedge clk);
            end
        end
    endtask

    // Scoreboard: every rx_dv pops the oldest expected frame of that instance.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (dv[u]) begin
                exp_t e;
                int   got;
                bit   empty;
                empty = (u == 0) ? (q0.size() == 0) : (u == 1) ? (q1.size() == 0) : (q2.size() == 0);
                if (empty) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_dv unit %0d: got rx_dv 1 expected 0", u);
                end else begin
                    case (u)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    got = (u == 0) ? int'(out0) : (u == 1) ? int'(out1) : int'(out2);
                    chk($sformatf("rx_out_u%0d", u), got, int'(e.data));
                    chk($sformatf("parity_err_u%0d", u), int'(pe[u]), int'(e.perr));
                    chk($sformatf("frame_err_u%0d", u), int'(fe[u]), int'(e.ferr));
                    chk($sformatf("break_det_u%0d", u), int'(bk[u]), int'(e.brk));
                end
            end
        end
    end

    initial begin
        // unit, align, data, par_inv, stop0, glitch, idle, exp data, perr, ferr, brk
        vecs.push_back(mk(0, 1, 9'h055, 0, 0, 0, 2, 9'h055, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h0F0, 0, 0, 0, 2, 9'h0F0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h03C, 0, 0, 0, 2, 9'h03C, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h03C, 0, 1, 0, 2, 9'h03C, 0, 1, 0));
        vecs.push_back(mk(0, 1, 9'h0C3, 0, 0, 1, 2, 9'h0C3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h0C3, 0, 0, 2, 2, 9'h0C7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h000, 0, 0, 0, 2, 9'h000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h0FF, 0, 0, 0, 2, 9'h0FF, 0, 0, 0));
        vecs.push_back(mk(1, 1, 9'h0A5, 0, 0, 0, 2, 9'h0A5, 0, 0, 0));
        vecs.push_back(mk(1, 1, 9'h0A5, 1, 0, 0, 2, 9'h0A5, 1, 0, 0));
        vecs.push_back(mk(1, 1, 9'h000, 1, 0, 0, 2, 9'h000, 1, 0, 0));
        vecs.push_back(mk(1, 1, 9'h001, 0, 0, 0, 2, 9'h001, 0, 0, 0));
        vecs.push_back(mk(1, 1, 9'h0A5, 0, 1, 0, 2, 9'h0A5, 0, 1, 0));
        vecs.push_back(mk(2, 1, 9'h012, 0, 0, 0, 0, 9'h012, 0, 0, 0));
        vecs.push_back(mk(2, 0, 9'h06D, 0, 0, 0, 2, 9'h06D, 0, 0, 0));
        vecs.push_back(mk(2, 1, 9'h07F, 0, 0, 0, 2, 9'h07F, 0, 0, 0));

        repeat (4) @(negedge clk);
        chk("reset_rx_out", int'(out0), 0);
        chk("reset_rx_dv", int'(dv), 0);
        chk("reset_flags", int'({pe, fe, bk}), 0);
        chk("reset_busy", int'(bz), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].align) align_tick();
            push_exp(vecs[i].unit, vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_brk);
            send_frame(vecs[i].unit, vecs[i].data, vecs[i].par_inv, vecs[i].stop0,
                       vecs[i].glitch, vecs[i].idle_bits, 0);
        end

        // Break: line low for 20 bit-times, then released.
        align_tick();
        push_exp(0, 9'h000, 0, 1, 1);
        for (int c = 0; c < 20 * BITCLK; c++) begin
            rxl[0] = 1'b0;
            if (c == 1800) chk("brk_busy_held", int'(bz[0]), 1);
            @(negedge clk);
        end
        rxl[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("brk_busy_release", int'(bz[0]), 0);
        repeat (2 * BITCLK) @(negedge clk);

        // False start: low for 4 ticks only, then a good 0x81 frame.
        align_tick();
        for (int c = 0; c < 100; c++) begin
            rxl[0] = (c < 32) ? 1'b0 : 1'b1;
            if (c == 40) chk("false_start_busy", int'(bz[0]), 1);
            if (c == 90) chk("false_start_idle", int'(bz[0]), 0);
            @(negedge clk);
        end
        repeat (2 * BITCLK) @(negedge clk);
        align_tick();
        push_exp(0, 9'h081, 0, 0, 0);
        send_frame(0, 9'h081, 0, 0, 0, 2, 0);

        // Reset in the middle of data bit 4, then a clean 0x5A frame.
        align_tick();
        send_frame(0, 9'h05A, 0, 0, 0, 0, 5 * BITCLK + 64);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rx_out", int'(out0), 0);
        chk("midreset_busy", int'(bz[0]), 0);
        chk("midreset_flags", int'({dv[0], pe[0], fe[0], bk[0]}), 0);
        rxl[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BITCLK) @(negedge clk);
        align_tick();
        push_exp(0, 9'h05A, 0, 0, 0);
        send_frame(0, 9'h05A, 0, 0, 0, 2, 0);

        repeat (4 * BITCLK) @(negedge clk);
        chk("missing_dv_u0", q0.size(), 0);
        chk("missing_dv_u1", q1.size(), 0);
        chk("missing_dv_u2", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
